mux2_arbiter: RTL
=================

// Module: mux2_arbiter
// PURPOSE
//  Round-robin arbiter sharing one WIDTH-bit datapath port between two requesters.
//  It drives the select of the 2:1 word mux and registers the selected word.
//  It presents the registered word downstream with a valid/ready handshake.
//  It sits in front of the ALU operand path, where two sources contend for one bus.
// PARAMETERS
//  WIDTH  32  data word width (in0, in1, out)
//  CNT_W  8   width of completed-transfer counter xfer_count
// PORTS
//  clk         in   1       single clock; all state updates on rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  req0        in   1       requester 0 has a word; held with in0 until gnt0
//  in0         in   WIDTH   requester 0 data
//  gnt0        out  1       combinational; in0 is captured at this clock edge
//  req1        in   1       requester 1 has a word; held with in1 until gnt1
//  in1         in   WIDTH   requester 1 data
//  gnt1        out  1       combinational; in1 is captured at this clock edge
//  out         out  WIDTH   registered selected word
//  out_valid   out  1       out holds an unconsumed word
//  out_ready   in   1       downstream accepts out when out_valid && out_ready
//  out_sel     out  1       registered source of out (0 = in0, 1 = in1)
//  xfer_count  out  CNT_W   count of completed downstream transfers
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - out=0, out_valid=0, out_sel=0, xfer_count=0, last=1.
//   - gnt0=gnt1=0 while reset_n is low.
//   - A word held in out is discarded.
//  State: EMPTY (out_valid=0) / FULL (out_valid=1).
//   - load = any_req && (EMPTY || out_ready); any_req = req0|req1.
//  Arbitration (combinational):
//   - Only req0 set -> winner 0. Only req1 set -> winner 1.
//   - Both set -> winner = ~last (round-robin). Tie after reset goes to 0.
//   - gnt_w = load for the winner; gnt of the loser = 0.
//   - gnt is never asserted without the matching req.
//  On a clock edge with load:
//   - out <= in_w; out_sel <= w; last <= w; out_valid <= 1.
//  On a clock edge with FULL && out_ready:
//   - xfer_count <= xfer_count+1; wraps modulo 2^CNT_W.
//   - If load is also true, the next word replaces out in the same edge
//     (back-to-back, no bubble) and out_valid stays 1.
//   - Otherwise out_valid <= 0.
//  FULL && !out_ready:
//   - out, out_sel and out_valid stay stable; gnt0=gnt1=0.
//  Latency: req -> out_valid one cycle when EMPTY.
//   - Throughput is one word per cycle while out_ready=1.
//  out_ready with EMPTY is ignored; xfer_count does not change.
//  A requester that drops req before its gnt forfeits the cycle; nothing is captured.
//  last is updated only on grants, so a lone requester never changes tie order
//   except through its own grants.
// TESTING
//  1 Reset: drive reset_n=0 mid-transfer with out_valid=1
//    -> out_valid=0, xfer_count=0, gnt0=gnt1=0 immediately, without waiting for clk.
//  2 Single: req0=1, in0=32'hDEADBEEF, out_ready=1
//    -> gnt0=1 that cycle; next cycle out=DEADBEEF, out_sel=0, out_valid=1.
//  3 Contention: req0=req1=1 held, out_ready=1, in0=A, in1=B for 4 cycles
//    -> grants 0,1,0,1; out sequence A,B,A,B; xfer_count advances by 1 per cycle.
//  4 Backpressure: out_ready=0 with FULL, req1=1 for 3 cycles
//    -> gnt1=0 and out stable; out_ready=1 -> gnt1=1 and out=in1 next edge, no bubble.
//  5 Wrap: CNT_W=2, 5 transfers -> xfer_count 1,2,3,0,1.
//  6 Idle: out_ready=1 with no req -> out_valid=0; xfer_count unchanged.

Source files
------------

// File: rtl/mux2_arbiter_if.sv
// Handshake bundle between two requesters, the shared word register and its downstream consumer.
interface mux2_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             req0;
  logic [WIDTH-1:0] in0;
  logic             gnt0;
  logic             req1;
  logic [WIDTH-1:0] in1;
  logic             gnt1;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             out_sel;
  logic [CNT_W-1:0] xfer_count;

  modport master (
    output req0, in0, req1, in1, out_ready,
    input  gnt0, gnt1, out, out_valid, out_sel, xfer_count
  );

  modport slave (
    input  req0, in0, req1, in1, out_ready,
    output gnt0, gnt1, out, out_valid, out_sel, xfer_count
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter that muxes two word sources into one registered output
// presented downstream through a valid/ready handshake.
module mux2_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  mux2_arbiter_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             last_q;
  logic             any_req, load, winner, drain;
  logic [WIDTH-1:0] out_q;
  logic             sel_q;
  logic [CNT_W-1:0] count_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // Next-state logic: a load always leaves a word behind; a drain without load empties
  always_comb begin
    state_d = state_q;
    if (load)       state_d = FULL;
    else if (drain) state_d = EMPTY;
  end

  // Output / arbitration logic; grants are held off while reset is asserted
  always_comb begin
    any_req  = bus.req0 | bus.req1;
    winner   = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
    load     = reset_n & any_req & ((state_q == EMPTY) | bus.out_ready);
    drain    = (state_q == FULL) & bus.out_ready;
    bus.gnt0 = load & ~winner;
    bus.gnt1 = load & winner;
  end

  // Word register, source tag, tie-break history and transfer counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      count_q <= '0;
    end else begin
      if (load) begin
        out_q  <= winner ? bus.in1 : bus.in0;
        sel_q  <= winner;
        last_q <= winner;
      end
      if (drain) count_q <= count_q + 1'b1;
    end
  end

  assign bus.out        = out_q;
  assign bus.out_sel    = sel_q;
  assign bus.out_valid  = (state_q == FULL);
  assign bus.xfer_count = count_q;

endmodule
